// File: rtl/serial_add_seq.sv
// Bit-serial adder sequencer: feeds one operand bit pair per cycle (LSB first) to an
// external 1-bit full adder and assembles the WIDTH-bit sum, carry-out and signed overflow.
module serial_add_seq #(
    parameter int WIDTH = 8,
    parameter int CW    = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_c,
    input  logic             fa_sum,
    input  logic             fa_carry,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic             carry_out,
    output logic             overflow
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic             c_q;
    logic             c_msb;
    logic [CW-1:0]    cnt;
    logic             last_bit;
    logic             msb_bit;

    assign last_bit = (cnt == CW'(WIDTH - 1));
    assign msb_bit  = (cnt == CW'(WIDTH - 2));

    always_comb begin
        state_nxt = state;
        fa_a      = 1'b0;
        fa_b      = 1'b0;
        fa_c      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = SHIFT;
            end
            SHIFT: begin
                fa_a = a_sh[0];
                fa_b = b_sh[0];
                fa_c = c_q;
                if (last_bit) state_nxt = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            a_sh      <= '0;
            b_sh      <= '0;
            res_sh    <= '0;
            c_q       <= 1'b0;
            c_msb     <= 1'b0;
            cnt       <= '0;
            sum_out   <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt == SHIFT);
            done  <= (state_nxt == DONE);
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh   <= a_in;
                        b_sh   <= b_in;
                        c_q    <= cin;
                        cnt    <= '0;
                        res_sh <= '0;
                    end
                end
                SHIFT: begin
                    a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
                    b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
                    res_sh <= {fa_sum, res_sh[WIDTH-1:1]};
                    c_q    <= fa_carry;
                    cnt    <= cnt + CW'(1);
                    // Carry into the MSB is needed later for the signed overflow flag.
                    if (msb_bit) c_msb <= fa_carry;
                    if (last_bit) begin
                        sum_out   <= {fa_sum, res_sh[WIDTH-1:1]};
                        carry_out <= fa_carry;
                        overflow  <= c_msb ^ fa_carry;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_seq.sv
// Bench for serial_add_seq: models the companion full adder, runs directed vectors,
// corner sequences (re-start, async reset, back-to-back) and random operands.
module tb_serial_add_seq;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             cin;
    logic             fa_a, fa_b, fa_c;
    logic             fa_sum, fa_carry;
    logic             busy, done;
    logic [WIDTH-1:0] sum_out;
    logic             carry_out, overflow;

    int n_cmp = 0;
    int n_err = 0;
    logic [WIDTH-1:0] prev_sum;

    always #5 clk = ~clk;

    // Companion 1-bit full adder
    assign fa_sum   = fa_a ^ fa_b ^ fa_c;
    assign fa_carry = (fa_a & fa_b) | (fa_a & fa_c) | (fa_b & fa_c);

    serial_add_seq #(.WIDTH(WIDTH), .CW(4)) dut (
        .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in), .cin(cin),
        .fa_a(fa_a), .fa_b(fa_b), .fa_c(fa_c), .fa_sum(fa_sum), .fa_carry(fa_carry),
        .busy(busy), .done(done), .sum_out(sum_out), .carry_out(carry_out),
        .overflow(overflow)
    );

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             c;
        bit               repulse;
        logic [WIDTH-1:0] exp_sum;
        logic             exp_cout;
        logic             exp_ovf;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Plain integer addition reference
    task automatic model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c,
                         output logic [WIDTH-1:0] s, output logic co, output logic ov);
        int unsigned total;
        int sa, sb, ss;
        total = int'(a) + int'(b) + int'(c);
        s  = total[WIDTH-1:0];
        co = total[WIDTH];
        sa = a[WIDTH-1] ? int'(a) - (1 << WIDTH) : int'(a);
        sb = b[WIDTH-1] ? int'(b) - (1 << WIDTH) : int'(b);
        ss = sa + sb + int'(c);
        ov = (ss > (1 << (WIDTH - 1)) - 1) || (ss < -(1 << (WIDTH - 1)));
    endtask

    // Called at #1 after a rising edge with the DUT idle; returns in the same position.
    task automatic run_op(input string nm, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic c, input bit repulse, input logic [WIDTH-1:0] es,
                          input logic eco, input logic eov);
        int busy_n, done_n;
        logic [WIDTH-1:0] seq_a, seq_b;
        bit held_ok;
        busy_n = 0; done_n = 0; seq_a = '0; seq_b = '0; held_ok = 1'b1;
        a_in = a; b_in = b; cin = c; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a_in = WIDTH'($urandom); b_in = WIDTH'($urandom); cin = 1'($urandom);
        for (int i = 0; i <= WIDTH; i++) begin
            if (busy) begin
                if (busy_n < WIDTH) begin
                    seq_a[busy_n] = fa_a;
                    seq_b[busy_n] = fa_b;
                end
                busy_n++;
                if (sum_out !== prev_sum) held_ok = 1'b0;
            end
            if (done) done_n++;
            start = 1'b0;
            if (repulse && ((busy && busy_n == 3) || done)) begin
                start = 1'b1; a_in = 8'hF0; b_in = 8'hF0; cin = 1'b1;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        chk({nm, " busy_width"}, busy_n, WIDTH);
        chk({nm, " done_pulses"}, done_n, 1);
        chk({nm, " fa_a_seq"}, seq_a, a);
        chk({nm, " fa_b_seq"}, seq_b, b);
        chk({nm, " sum_held"}, held_ok, 1);
        chk({nm, " sum_out"}, sum_out, es);
        chk({nm, " carry_out"}, carry_out, eco);
        chk({nm, " overflow"}, overflow, eov);
        chk({nm, " idle_after"}, {busy, done}, 2'b00);
        prev_sum = es;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs[5];
        logic [WIDTH-1:0] ms;
        logic mco, mov;
        logic [WIDTH-1:0] ra, rb;
        logic rc;
        bit done_seen;

        vecs[0] = '{8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[3] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[4] = '{8'h01, 8'h02, 1'b0, 1'b1, 8'h03, 1'b0, 1'b0};

        rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0; cin = 1'b0;
        prev_sum = '0;
        @(posedge clk); @(posedge clk); #1;
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset sum_out", sum_out, 0);
        chk("reset carry_out", carry_out, 0);
        chk("reset overflow", overflow, 0);
        chk("reset fa", {fa_a, fa_b, fa_c}, 3'b000);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 5; i++)
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].repulse,
                   vecs[i].exp_sum, vecs[i].exp_cout, vecs[i].exp_ovf);

        // Asynchronous reset in the middle of busy cycle 4
        a_in = 8'h11; b_in = 8'h22; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
        end
        chk("rst_mid busy_before", busy, 1);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid busy", busy, 0);
        chk("rst_mid done", done, 0);
        chk("rst_mid sum_out", sum_out, 0);
        chk("rst_mid flags", {carry_out, overflow}, 2'b00);
        chk("rst_mid fa", {fa_a, fa_b, fa_c}, 3'b000);
        done_seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (done) done_seen = 1'b1;
        end
        rst = 1'b0;
        for (int i = 0; i < WIDTH + 2; i++) begin
            @(posedge clk); #1;
            if (done || busy) done_seen = 1'b1;
        end
        chk("rst_mid no_done", done_seen, 0);
        prev_sum = '0;

        run_op("after_rst", 8'h11, 8'h22, 1'b0, 1'b0, 8'h33, 1'b0, 1'b0);
        run_op("back2back", 8'h10, 8'h20, 1'b0, 1'b0, 8'h30, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            rc = 1'($urandom);
            if (i == 0) begin ra = 8'hFF; rb = 8'hFF; rc = 1'b1; end
            if (i == 1) begin ra = 8'h00; rb = 8'h00; rc = 1'b0; end
            model(ra, rb, rc, ms, mco, mov);
            run_op($sformatf("rand%0d", i), ra, rb, rc, (i % 7) == 3, ms, mco, mov);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
